// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> MEM -> WB, with a TRAP state.
// Owns the instruction register, drives the datapath selects, and traps when a memory wait times out.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_REQ,
    input  logic        IMEM_VALID,
    input  logic [31:0] IMEM_RDATA,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    input  logic        DMEM_ACK,
    input  logic        BR_TAKEN,
    output logic [31:0] IR,
    output logic [2:0]  IMM_TYPE,
    output logic [1:0]  ALU_SRC_A,
    output logic        ALU_SRC_B,
    output logic        RF_WE,
    output logic [1:0]  WB_SEL,
    output logic        PC_EN,
    output logic [1:0]  PC_SEL,
    output logic        INSTRET,
    output logic        ILLEGAL
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    state_e             state_q, state_d;
    logic [31:0]        ir_q, ir_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic [4:0] opcode;
    logic       legal;
    logic       tmo_hit;
    logic [2:0] imm_type;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic       imem_req, dmem_req, dmem_we, rf_we, pc_en, instret, illegal;
    logic [1:0] wb_sel, pc_sel;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_FETCH;
            ir_q    <= 32'h0000_0013;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            tmo_q   <= tmo_d;
        end
    end

    // Decode of the held instruction; valid in every state.
    always_comb begin
        opcode    = ir_q[6:2];
        imm_type  = 3'd0;
        alu_src_a = 2'd0;
        alu_src_b = 1'b1;
        legal     = 1'b0;
        case (opcode)
            OPC_OP:       begin imm_type = 3'd0; alu_src_b = 1'b0; legal = 1'b1; end
            OPC_OP_IMM,
            OPC_LOAD,
            OPC_JALR:     begin imm_type = 3'd1; legal = 1'b1; end
            OPC_STORE:    begin imm_type = 3'd2; legal = 1'b1; end
            OPC_BRANCH:   begin imm_type = 3'd3; alu_src_b = 1'b0; legal = 1'b1; end
            OPC_LUI:      begin imm_type = 3'd4; alu_src_a = 2'd2; legal = 1'b1; end
            OPC_AUIPC:    begin imm_type = 3'd4; alu_src_a = 2'd1; legal = 1'b1; end
            OPC_JAL:      begin imm_type = 3'd5; legal = 1'b1; end
            OPC_SYSTEM:   imm_type = 3'd6;
            OPC_MISC_MEM: legal = 1'b1;
            default:      imm_type = 3'd0;
        endcase
        if (ir_q[1:0] != 2'b11) legal = 1'b0;
    end

    // The last permitted wait cycle; a VALID/ACK seen in this cycle still wins.
    assign tmo_hit = (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

    // tmo_d defaults to zero, so the counter is clear on every entry to FETCH or MEM.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        tmo_d    = '0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 2'd0;
        pc_en    = 1'b0;
        pc_sel   = 2'd0;
        instret  = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (IMEM_VALID) begin
                    ir_d    = IMEM_RDATA;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
                    state_d = S_MEM;
                end else if (opcode == OPC_BRANCH) begin
                    pc_en   = 1'b1;
                    pc_sel  = {1'b0, BR_TAKEN};
                    instret = 1'b1;
                    state_d = S_FETCH;
                end else if (opcode == OPC_MISC_MEM) begin
                    pc_en   = 1'b1;
                    instret = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OPC_STORE);
                if (DMEM_ACK) begin
                    if (opcode == OPC_STORE) begin
                        pc_en   = 1'b1;
                        instret = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_en   = 1'b1;
                instret = 1'b1;
                wb_sel  = (opcode == OPC_LOAD) ? 2'd1 :
                          (opcode == OPC_JAL || opcode == OPC_JALR) ? 2'd2 : 2'd0;
                pc_sel  = (opcode == OPC_JAL) ? 2'd1 : (opcode == OPC_JALR) ? 2'd2 : 2'd0;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
                pc_en   = 1'b1;
                pc_sel  = 2'd3;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every output in the same cycle so outstanding requests drop at once.
    assign IMEM_REQ  = imem_req & ~RESET;
    assign DMEM_REQ  = dmem_req & ~RESET;
    assign DMEM_WE   = dmem_we & ~RESET;
    assign RF_WE     = rf_we & ~RESET;
    assign PC_EN     = pc_en & ~RESET;
    assign INSTRET   = instret & ~RESET;
    assign ILLEGAL   = illegal & ~RESET;
    assign ALU_SRC_B = alu_src_b & ~RESET;
    assign WB_SEL    = RESET ? 2'd0 : wb_sel;
    assign PC_SEL    = RESET ? 2'd0 : pc_sel;
    assign ALU_SRC_A = RESET ? 2'd0 : alu_src_a;
    assign IMM_TYPE  = RESET ? 3'd0 : imm_type;
    assign IR        = RESET ? 32'd0 : ir_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each instruction into the
// expected per-cycle output trace, which is compared against the DUT cycle by cycle.
module tb_multicycle_ctrl;
    localparam int TMO = 15;

    logic        CLK, RESET;
    logic        IMEM_REQ, IMEM_VALID, DMEM_REQ, DMEM_WE, DMEM_ACK, BR_TAKEN;
    logic [31:0] IMEM_RDATA, IR;
    logic [2:0]  IMM_TYPE;
    logic [1:0]  ALU_SRC_A, WB_SEL, PC_SEL;
    logic        ALU_SRC_B, RF_WE, PC_EN, INSTRET, ILLEGAL;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .TMO_W(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .IMEM_REQ(IMEM_REQ), .IMEM_VALID(IMEM_VALID), .IMEM_RDATA(IMEM_RDATA),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ACK(DMEM_ACK),
        .BR_TAKEN(BR_TAKEN), .IR(IR), .IMM_TYPE(IMM_TYPE),
        .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .RF_WE(RF_WE),
        .WB_SEL(WB_SEL), .PC_EN(PC_EN), .PC_SEL(PC_SEL),
        .INSTRET(INSTRET), .ILLEGAL(ILLEGAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Output vector: {IR, IMEM_REQ, DMEM_REQ, DMEM_WE, RF_WE, WB_SEL, PC_EN, PC_SEL,
    //                 INSTRET, ILLEGAL, IMM_TYPE, ALU_SRC_A, ALU_SRC_B}
    // Input vector:  {IMEM_VALID, IMEM_RDATA, DMEM_ACK, BR_TAKEN}
    logic [48:0] exp_q[$];
    logic [34:0] in_q[$];
    logic [31:0] prev_ir;
    int          vectors;
    int          miscompares;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR, K_FENCE, K_ILL} kind_e;

    function automatic kind_e kind_of(input logic [31:0] ir);
        if (ir[1:0] != 2'b11) return K_ILL;
        case (ir[6:0])
            7'h33, 7'h13, 7'h37, 7'h17: return K_ALU;
            7'h03: return K_LOAD;
            7'h23: return K_STORE;
            7'h63: return K_BRANCH;
            7'h6F: return K_JAL;
            7'h67: return K_JALR;
            7'h0F: return K_FENCE;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [5:0] sel_of(input logic [31:0] ir);
        // {IMM_TYPE, ALU_SRC_A, ALU_SRC_B} from the format table
        case (ir[6:2])
            5'b01100: return {3'd0, 2'd0, 1'b0};
            5'b00100, 5'b00000, 5'b11001: return {3'd1, 2'd0, 1'b1};
            5'b01000: return {3'd2, 2'd0, 1'b1};
            5'b11000: return {3'd3, 2'd0, 1'b0};
            5'b01101: return {3'd4, 2'd2, 1'b1};
            5'b00101: return {3'd4, 2'd1, 1'b1};
            5'b11011: return {3'd5, 2'd0, 1'b1};
            5'b11100: return {3'd6, 2'd0, 1'b1};
            default:  return {3'd0, 2'd0, 1'b1};
        endcase
    endfunction

    function automatic logic [48:0] ev(input logic [31:0] ir, input logic ireq, dreq, dwe, rfwe,
                                       input logic [1:0] wbs, input logic pce,
                                       input logic [1:0] pcs, input logic ret, ill);
        return {ir, ireq, dreq, dwe, rfwe, wbs, pce, pcs, ret, ill, sel_of(ir)};
    endfunction

    function automatic logic [34:0] noise();
        return {1'($urandom), 32'($urandom), 1'($urandom), 1'($urandom)};
    endfunction

    task automatic push(input logic [34:0] in, input logic [48:0] e);
        in_q.push_back(in);
        exp_q.push_back(e);
    endtask

    // Expand one instruction into input stimulus and expected outputs.
    // lf/lm: wait cycles before VALID/ACK; TMO or more means it never arrives.
    task automatic build_instr(input logic [31:0] ir, input int lf, input int lm, input logic br);
        kind_e k;
        bit    got_it;
        got_it = 0;
        for (int c = 0; c < TMO; c++) begin
            if (c == lf) begin
                push({1'b1, ir, 1'($urandom), 1'($urandom)}, ev(prev_ir, 1, 0, 0, 0, 0, 0, 0, 0, 0));
                got_it = 1;
                break;
            end
            push({1'b0, 32'($urandom), 1'($urandom), 1'($urandom)},
                 ev(prev_ir, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        if (!got_it) begin
            push(noise(), ev(prev_ir, 0, 0, 0, 0, 0, 1, 3, 0, 1));
            return;
        end
        prev_ir = ir;
        k = kind_of(ir);
        push(noise(), ev(ir, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (k == K_ILL) begin
            push(noise(), ev(ir, 0, 0, 0, 0, 0, 1, 3, 0, 1));
            return;
        end
        if (k == K_BRANCH) begin
            push({1'($urandom), 32'($urandom), 1'($urandom), br},
                 ev(ir, 0, 0, 0, 0, 0, 1, {1'b0, br}, 1, 0));
            return;
        end
        if (k == K_FENCE) begin
            push(noise(), ev(ir, 0, 0, 0, 0, 0, 1, 0, 1, 0));
            return;
        end
        push(noise(), ev(ir, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (k == K_LOAD || k == K_STORE) begin
            got_it = 0;
            for (int c = 0; c < TMO; c++) begin
                if (c == lm) begin
                    push({1'($urandom), 32'($urandom), 1'b1, 1'($urandom)},
                         ev(ir, 0, 1, k == K_STORE, 0, 0, k == K_STORE, 0, k == K_STORE, 0));
                    got_it = 1;
                    break;
                end
                push({1'($urandom), 32'($urandom), 1'b0, 1'($urandom)},
                     ev(ir, 0, 1, k == K_STORE, 0, 0, 0, 0, 0, 0));
            end
            if (!got_it) begin
                push(noise(), ev(ir, 0, 0, 0, 0, 0, 1, 3, 0, 1));
                return;
            end
            if (k == K_STORE) return;
        end
        push(noise(), ev(ir, 0, 0, 0, 1,
                         (k == K_LOAD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0,
                         1, (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0, 1, 0));
    endtask

    task automatic drive_cycle(input logic [34:0] in, output logic [48:0] got);
        {IMEM_VALID, IMEM_RDATA, DMEM_ACK, BR_TAKEN} = in;
        @(negedge CLK);
        got = {IR, IMEM_REQ, DMEM_REQ, DMEM_WE, RF_WE, WB_SEL, PC_EN, PC_SEL,
               INSTRET, ILLEGAL, IMM_TYPE, ALU_SRC_A, ALU_SRC_B};
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [48:0] got;
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(noise(), got);
            vectors++;
            if (got !== 49'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: got=%h exp=%h", got, 49'd0);
            end
        end
        RESET = 1'b0;
        prev_ir = 32'h0000_0013;
    endtask

    task automatic test_alu();
        logic [48:0] got, exp_v;
        int pc_en_cnt, ret_cnt;
        pc_en_cnt = 0;
        ret_cnt = 0;
        build_instr(32'h0050_0093, 2, 0, 1'b0);
        while (in_q.size() > 0) begin
            drive_cycle(in_q.pop_front(), got);
            exp_v = exp_q.pop_front();
            pc_en_cnt += int'(got[10]);
            ret_cnt += int'(got[7]);
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL alu_trace: got=%h exp=%h", got, exp_v);
            end
        end
        vectors++;
        if (pc_en_cnt !== 1 || ret_cnt !== 1) begin
            miscompares++;
            $display("FAIL alu_pulses: pc_en=%0d instret=%0d exp=1/1", pc_en_cnt, ret_cnt);
        end
    endtask

    task automatic test_branch();
        logic [48:0] got, exp_v;
        build_instr(32'h0000_0463, 0, 0, 1'b1);
        build_instr(32'h0000_0463, 1, 0, 1'b0);
        while (in_q.size() > 0) begin
            drive_cycle(in_q.pop_front(), got);
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL branch_trace: got=%h exp=%h", got, exp_v);
            end
        end
    endtask

    task automatic test_mem();
        logic [48:0] got, exp_v;
        build_instr(32'h0000_A103, 0, 3, 1'b0);
        build_instr(32'h0020_A023, 1, 0, 1'b0);
        build_instr(32'h0020_A023, 0, 2, 1'b0);
        while (in_q.size() > 0) begin
            drive_cycle(in_q.pop_front(), got);
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL mem_trace: got=%h exp=%h", got, exp_v);
            end
        end
    endtask

    task automatic test_jumps();
        logic [48:0] got, exp_v;
        build_instr(32'h0080_00EF, 0, 0, 1'b0);
        build_instr(32'h0000_80E7, 1, 0, 1'b0);
        build_instr(32'h1234_50B7, 0, 0, 1'b0);
        build_instr(32'h0000_1097, 2, 0, 1'b0);
        build_instr(32'h0000_000F, 0, 0, 1'b0);
        while (in_q.size() > 0) begin
            drive_cycle(in_q.pop_front(), got);
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL jump_trace: got=%h exp=%h", got, exp_v);
            end
        end
    endtask

    task automatic test_traps();
        logic [48:0] got, exp_v;
        build_instr(32'h0000_0073, 0, 0, 1'b0);
        build_instr(32'h0000_0000, 1, 0, 1'b0);
        while (in_q.size() > 0) begin
            drive_cycle(in_q.pop_front(), got);
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL trap_trace: got=%h exp=%h", got, exp_v);
            end
        end
    endtask

    task automatic test_timeout();
        logic [48:0] got, exp_v;
        build_instr(32'h0050_0093, TMO, 0, 1'b0);
        build_instr(32'h0050_0093, TMO - 1, 0, 1'b0);
        build_instr(32'h0000_A103, 0, TMO, 1'b0);
        build_instr(32'h0020_A023, 0, TMO - 1, 1'b0);
        while (in_q.size() > 0) begin
            drive_cycle(in_q.pop_front(), got);
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL timeout_trace: got=%h exp=%h", got, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [48:0] got, exp_v;
        build_instr(32'h0000_A103, 0, TMO, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(in_q.pop_front(), got);
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL mid_mem_pre: got=%h exp=%h", got, exp_v);
            end
        end
        in_q.delete();
        exp_q.delete();
        RESET = 1'b1;
        drive_cycle({1'b1, 32'($urandom), 1'b1, 1'b1}, got);
        vectors++;
        if (got !== 49'd0) begin
            miscompares++;
            $display("FAIL mid_mem_reset: got=%h exp=%h", got, 49'd0);
        end
        RESET = 1'b0;
        prev_ir = 32'h0000_0013;
        build_instr(32'h0030_0113, 1, 0, 1'b0);
        while (in_q.size() > 0) begin
            drive_cycle(in_q.pop_front(), got);
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL mid_mem_post: got=%h exp=%h", got, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [48:0] got, exp_v;
        logic [31:0] ir;
        int lf, lm;
        for (int n = 0; n < 60; n++) begin
            ir = $urandom;
            case ($urandom_range(0, 12))
                0:  ir[6:0] = 7'h33;
                1:  ir[6:0] = 7'h13;
                2:  ir[6:0] = 7'h03;
                3:  ir[6:0] = 7'h23;
                4:  ir[6:0] = 7'h63;
                5:  ir[6:0] = 7'h6F;
                6:  ir[6:0] = 7'h67;
                7:  ir[6:0] = 7'h37;
                8:  ir[6:0] = 7'h17;
                9:  ir[6:0] = 7'h0F;
                10: ir[6:0] = 7'h73;
                11: ir[1:0] = 2'b11;
                default: ir[1:0] = 2'($urandom_range(0, 2));
            endcase
            lf = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 1, TMO) : $urandom_range(0, 3);
            lm = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 1, TMO) : $urandom_range(0, 3);
            build_instr(ir, lf, lm, 1'($urandom));
        end
        while (in_q.size() > 0) begin
            drive_cycle(in_q.pop_front(), got);
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL random_trace: got=%h exp=%h", got, exp_v);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        prev_ir = 32'h0000_0013;
        RESET = 1'b1;
        {IMEM_VALID, IMEM_RDATA, DMEM_ACK, BR_TAKEN} = '0;
        @(posedge CLK);
        #1;
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_jumps();
        test_traps();
        test_timeout();
        test_reset_mid_mem();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
